// File: rtl/sdio_tb_pkg.sv
// Shared types and defaults for the SDIO cocotb harness controller:
// test-phase state encoding and default parameter values.
package sdio_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DUT_RST = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int DEF_RST_HOLD  = 8;
  localparam int DEF_CNT_WIDTH = 32;

endpackage

// File: rtl/sdio_tb_stim_reg.sv
// One stimulus channel: registers a cocotb-driven value so the DUT never
// sees it while Python is still writing it.
module sdio_tb_stim_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its inputs, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/sdio_tb_ctrl.sv
// Harness controller: registered stimulus, per-test DUT reset sequencing,
// test ID latch, run-cycle counter and watchdog.
module sdio_tb_ctrl
  import sdio_tb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CH_WIDTH  = 8,
  parameter int RST_HOLD  = DEF_RST_HOLD,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                i_test_id,
  input  logic                       i_test_start,
  input  logic                       i_test_end,
  input  logic [CNT_WIDTH-1:0]       i_timeout_limit,
  input  logic [NUM_CH*CH_WIDTH-1:0] i_stim,
  output logic [NUM_CH*CH_WIDTH-1:0] o_stim,
  output logic                       o_dut_rst,
  output logic [31:0]                o_test_id,
  output logic                       o_running,
  output logic                       o_done,
  output logic                       o_timeout,
  output logic [CNT_WIDTH-1:0]       o_cycle_count
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt, cnt_inc;
  logic [31:0]           id_nxt;
  logic                  start_q, start_d, start_edge;

  // Edge taken between two registered copies, so the raw cocotb level is
  // never used directly by the FSM.
  assign start_edge = start_q & ~start_d;
  assign cnt_inc    = o_cycle_count + CNT_WIDTH'(1);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sdio_tb_stim_reg #(.WIDTH(CH_WIDTH)) u_stim_reg (
      .clk (clk),
      .rst (rst),
      .d   (i_stim[k*CH_WIDTH +: CH_WIDTH]),
      .q   (o_stim[k*CH_WIDTH +: CH_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cnt_nxt   = o_cycle_count;
    id_nxt    = o_test_id;
    unique case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_edge) begin
          state_nxt = ST_DUT_RST;
          hold_nxt  = HOLD_LOAD;
          cnt_nxt   = '0;
          id_nxt    = i_test_id;
        end
      end
      ST_DUT_RST: begin
        if (hold_cnt == '0) state_nxt = ST_RUN;
        else                hold_nxt  = hold_cnt - HOLD_W'(1);
      end
      ST_RUN: begin
        cnt_nxt = (&o_cycle_count) ? o_cycle_count : cnt_inc;
        // Test end wins over a watchdog expiry in the same cycle.
        if (i_test_end)
          state_nxt = ST_DONE;
        else if ((i_timeout_limit != '0) && (cnt_inc == i_timeout_limit))
          state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the
  // same edge as the FSM and stay mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q       <= 1'b0;
      start_d       <= 1'b0;
      hold_cnt      <= '0;
      o_cycle_count <= '0;
      o_test_id     <= '0;
      o_dut_rst     <= 1'b1;
      o_running     <= 1'b0;
      o_done        <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      start_q       <= i_test_start;
      start_d       <= start_q;
      hold_cnt      <= hold_nxt;
      o_cycle_count <= cnt_nxt;
      o_test_id     <= id_nxt;
      o_dut_rst     <= (state_nxt == ST_IDLE) || (state_nxt == ST_DUT_RST);
      o_running     <= (state_nxt == ST_RUN);
      o_done        <= (state_nxt == ST_DONE);
      o_timeout     <= (state_nxt == ST_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_sdio_tb_ctrl.sv
// Directed bench for sdio_tb_ctrl: scoreboarded stimulus pipeline plus
// reset, normal test, watchdog, restart/ignore and mid-test reset sequences.
module tb_sdio_tb_ctrl;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 8;
  localparam int HOLD   = 8;
  localparam int CW     = 32;
  localparam int SW     = NUM_CH * CH_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   test_id;
  logic          test_start;
  logic          test_end;
  logic [CW-1:0] limit;
  logic [SW-1:0] stim;
  logic [SW-1:0] o_stim;
  logic          o_dut_rst;
  logic [31:0]   o_test_id;
  logic          o_running;
  logic          o_done;
  logic          o_timeout;
  logic [CW-1:0] o_cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [SW-1:0] sb[$];

  always #5 clk = ~clk;

  sdio_tb_ctrl #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_W), .RST_HOLD(HOLD), .CNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_test_id       (test_id),
    .i_test_start    (test_start),
    .i_test_end      (test_end),
    .i_timeout_limit (limit),
    .i_stim          (stim),
    .o_stim          (o_stim),
    .o_dut_rst       (o_dut_rst),
    .o_test_id       (o_test_id),
    .o_running       (o_running),
    .o_done          (o_done),
    .o_timeout       (o_timeout),
    .o_cycle_count   (o_cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic run, input logic done,
                        input logic to, input logic drst, input logic [CW-1:0] cnt);
    chk({tag, ".running"}, 64'(o_running), 64'(run));
    chk({tag, ".done"},    64'(o_done),    64'(done));
    chk({tag, ".timeout"}, 64'(o_timeout), 64'(to));
    chk({tag, ".dut_rst"}, 64'(o_dut_rst), 64'(drst));
    chk({tag, ".count"},   64'(o_cycle_count), 64'(cnt));
  endtask

  // One clock: drive stimulus, queue its expected registered image, then
  // compare the registered output one edge later.
  task automatic tick(input logic [SW-1:0] v);
    logic [SW-1:0] exp;
    stim = v;
    sb.push_back(rst ? '0 : v);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk("stim", 64'(o_stim), 64'(exp));
  endtask

  task automatic tk();
    tick($urandom());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tk();
  endtask

  // Start pulse through RUN entry, checking the reset-hold window.
  task automatic start_test(input logic [31:0] id);
    test_id    = id;
    test_start = 1'b1;
    tk();
    test_start = 1'b0;
    tk();
    chk_st("rst_entry", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("rst_entry.id", 64'(o_test_id), 64'(id));
    for (int i = 0; i < HOLD - 1; i++) begin
      tk();
      chk("hold.dut_rst", 64'(o_dut_rst), 64'd1);
      chk("hold.running", 64'(o_running), 64'd0);
    end
    tk();
    chk_st("run_entry", 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst        = 1'b1;
    test_id    = '0;
    test_start = 1'b0;
    test_end   = 1'b0;
    limit      = '0;
    stim       = '0;

    // Reset then idle
    ticks(3);
    chk_st("reset", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("reset.id", 64'(o_test_id), 64'd0);
    rst = 1'b0;
    tick(32'hA55A0FF0);
    tick(32'h0);
    ticks(3);
    chk_st("idle", 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Normal test: end asserted in the 100th RUN cycle
    start_test(32'd7);
    tk();
    chk("first_run.count", 64'(o_cycle_count), 64'd1);
    ticks(98);
    chk_st("run99", 1'b1, 1'b0, 1'b0, 1'b0, 32'd99);
    test_end = 1'b1;
    tk();
    test_end = 1'b0;
    chk_st("done", 1'b0, 1'b1, 1'b0, 1'b0, 32'd100);
    ticks(4);
    chk("done.frozen", 64'(o_cycle_count), 64'd100);
    chk("done.sticky", 64'(o_done), 64'd1);

    // Watchdog L=50, no test end
    limit = 32'd50;
    start_test(32'd20);
    ticks(49);
    chk_st("wd49", 1'b1, 1'b0, 1'b0, 1'b0, 32'd49);
    tk();
    chk_st("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 32'd50);
    ticks(5);
    chk_st("timeout.sticky", 1'b0, 1'b0, 1'b1, 1'b0, 32'd50);

    // Watchdog L=50 with test end in the 50th cycle: end wins
    start_test(32'd21);
    ticks(49);
    test_end = 1'b1;
    tk();
    test_end = 1'b0;
    chk_st("end_wins", 1'b0, 1'b1, 1'b0, 1'b0, 32'd50);
    limit = '0;

    // Restart from DONE with ID 8, then ignored start in RUN, held high
    start_test(32'd8);
    ticks(10);
    test_id    = 32'd9;
    test_start = 1'b1;
    ticks(5);
    chk_st("ignore_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'd15);
    chk("ignore_run.id", 64'(o_test_id), 64'd8);
    test_end = 1'b1;
    tk();
    test_end = 1'b0;
    chk_st("held.done", 1'b0, 1'b1, 1'b0, 1'b0, 32'd16);
    ticks(6);
    chk_st("held.no_retrig", 1'b0, 1'b1, 1'b0, 1'b0, 32'd16);
    chk("held.id", 64'(o_test_id), 64'd8);
    test_start = 1'b0;
    tk();

    // Mid-test reset during DUT_RST
    test_id    = 32'd5;
    test_start = 1'b1;
    tk();
    test_start = 1'b0;
    ticks(3);
    chk("midrst.in_hold", 64'(o_dut_rst), 64'd1);
    rst = 1'b1;
    tk();
    chk_st("midrst_hold", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("midrst_hold.id", 64'(o_test_id), 64'd0);
    rst = 1'b0;
    ticks(12);
    chk_st("midrst_hold.idle", 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Mid-test reset during RUN
    start_test(32'd7);
    ticks(5);
    chk("midrst.run_count", 64'(o_cycle_count), 64'd5);
    rst = 1'b1;
    tk();
    chk_st("midrst_run", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("midrst_run.id", 64'(o_test_id), 64'd0);
    rst = 1'b0;
    tk();

    // Post-reset test behaves like the normal one
    start_test(32'd7);
    ticks(99);
    test_end = 1'b1;
    tk();
    test_end = 1'b0;
    chk_st("post_rst.done", 1'b0, 1'b1, 1'b0, 1'b0, 32'd100);
    chk("post_rst.id", 64'(o_test_id), 64'd7);
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdio_tb_ctrl.md
# sdio_tb_ctrl

Parametrised simulation harness controller for the SDIO device cocotb environment. It sits between the cocotb driver and the DUT top. It registers all cocotb-driven stimulus, so values are never sampled while Python is still writing them. It also sequences a per-test DUT reset, latches the test ID, counts run cycles and enforces a watchdog timeout. It replaces the fixed single-reset wrapper with an N-channel, width-configurable block that has explicit test-phase state.

## Interface
Parameters:
- NUM_CH, 4: number of registered stimulus channels
- CH_WIDTH, 8: bits per stimulus channel
- RST_HOLD, 8: cycles `o_dut_rst` is held high per test start (≥1)
- CNT_WIDTH, 32: width of the cycle counter and timeout limit

Ports:
- clk, in, 1: sole clock
- rst, in, 1: reset, synchronous, active-high
- i_test_id, in, 32: test identifier from cocotb
- i_test_start, in, 1: pulse or level; a rising edge starts a test
- i_test_end, in, 1: cocotb declares the test finished
- i_timeout_limit, in, CNT_WIDTH: watchdog limit in RUN cycles; 0 disables the watchdog
- i_stim, in, NUM_CH*CH_WIDTH: raw cocotb stimulus, channel k = bits [k*CH_WIDTH +: CH_WIDTH]
- o_stim, out, NUM_CH*CH_WIDTH: registered stimulus to the DUT
- o_dut_rst, out, 1: DUT reset, active-high
- o_test_id, out, 32: test ID latched at start
- o_running, out, 1: high in RUN
- o_done, out, 1: high in DONE
- o_timeout, out, 1: high in TIMEOUT
- o_cycle_count, out, CNT_WIDTH: RUN cycles elapsed

## Operation
- FSM states: IDLE, DUT_RST, RUN, DONE, TIMEOUT.
- Start edge detect uses a registered copy of `i_test_start`. A start edge is accepted only in IDLE, DONE or TIMEOUT and is ignored in DUT_RST and RUN.
- On an accepted start edge:
  - latch `i_test_id`
  - clear `o_cycle_count`
  - load the hold counter with RST_HOLD-1
  - go to DUT_RST
- DUT_RST:
  - `o_dut_rst`=1
  - the hold counter decrements each cycle
  - at 0, go to RUN
- RUN:
  - `o_cycle_count` increments each cycle and saturates at all-ones.
  - `i_test_end`=1 → DONE.
  - Otherwise, if the limit is nonzero and count+1 == limit → TIMEOUT.
  - If `i_test_end` and the timeout condition occur in the same cycle, `i_test_end` wins (DONE).
- DONE and TIMEOUT are sticky until the next start edge or `rst`. `o_cycle_count` is frozen in both.
- `o_stim` always equals `i_stim` delayed by one `clk`, independent of state, including during DUT_RST.
- Reset at any point, including mid-test: all outputs return to reset values on the next edge, the FSM goes to IDLE, and any in-progress hold count is abandoned.
- Reset values:
  - `o_stim`=0
  - `o_dut_rst`=1 (DUT held in reset while idle)
  - `o_test_id`=0
  - `o_running`=0, `o_done`=0, `o_timeout`=0
  - `o_cycle_count`=0
  - start-edge register=0
- In IDLE `o_dut_rst` stays 1. It deasserts only when the FSM enters RUN.

## Timing
- Stimulus latency: 1 cycle.
- Start edge sampled at edge N → DUT_RST from N+1 → `o_dut_rst` falls and `o_running` rises at edge N+RST_HOLD+1.
- `o_cycle_count` reads 1 after the first RUN cycle.
- Limit L: `o_timeout` asserts at the edge after the L-th RUN cycle, with `o_cycle_count`=L.
- Status outputs are registered and flags are mutually exclusive.

## Configuration
- `SDIO_TB_CTRL_VCD_EN`:
  - Defined: an initial block runs `$dumpfile("design.vcd")` and `$dumpvars(0, sdio_tb_ctrl)`.
  - Undefined: no dump calls and no simulation-only constructs; the block is synthesizable.

## Structure
- Shared package `sdio_tb_pkg` holds the state enum (3-bit encoding: IDLE=0, DUT_RST=1, RUN=2, DONE=3, TIMEOUT=4) and the default constants for RST_HOLD and CNT_WIDTH.
- One natural sub-module: `sdio_tb_stim_reg`. It is a single channel CH_WIDTH register with sync reset, instantiated NUM_CH times via generate.

## Test plan
- Reset then idle: `rst`=1 for 3 cycles → all status flags 0, `o_dut_rst`=1, `o_stim`=0, `o_cycle_count`=0.
- Stimulus pipeline, NUM_CH=4, CH_WIDTH=8: drive `i_stim`=0xA55A0FF0 → `o_stim`=0xA55A0FF0 exactly one cycle later; DUT_RST and RUN do not affect it.
- Normal test: `i_test_id`=7, start edge, RST_HOLD=8 → `o_dut_rst` high 8 cycles after DUT_RST entry, `o_test_id`=7. Assert `i_test_end` after 100 RUN cycles → `o_done`=1, `o_cycle_count`=100.
- Watchdog, L=50, no `i_test_end` → `o_timeout`=1, `o_cycle_count`=50. Repeat with L=50 and `i_test_end` asserted in the 50th cycle → `o_done`=1, `o_timeout`=0.
- Restart and ignore:
  - Start edge during RUN is ignored.
  - Start edge from DONE relaunches DUT_RST with the new ID 8 and count cleared.
  - Holding `i_test_start` high does not retrigger.
- Mid-test reset: `rst` asserted in DUT_RST and again in RUN → IDLE next cycle with all outputs at reset values. The next start edge behaves exactly like the normal-test scenario.
